// File: rtl/multiplier_opt_seq.sv
// Sequential unsigned multiplier: radix-2 shift-and-add, one partial product per clock.
// Each period is LOAD, W CALC steps, then DONE, which publishes the product on result.
module multiplier_opt_seq #(
  parameter int W = 3
) (
  input  logic           clk,
  input  logic           rstn,
  input  logic [W-1:0]   num1,
  input  logic [W-1:0]   num2,
  output logic [2*W-1:0] result
);

  localparam int CW = $clog2(W + 1);
  localparam logic [CW-1:0] LAST_STEP = CW'(W - 1);

  localparam logic [1:0] LOAD = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]     state;
  logic [2*W-1:0] mcand;
  logic [2*W-1:0] acc;
  logic [W-1:0]   mplier;
  logic [CW-1:0]  count;

  // rstn is active-high despite its name; it aborts any calculation in flight.
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      state  <= LOAD;
      mcand  <= '0;
      acc    <= '0;
      mplier <= '0;
      count  <= '0;
      result <= '0;
    end else begin
      case (state)
        LOAD: begin
          mcand  <= {{W{1'b0}}, num1};
          mplier <= num2;
          acc    <= '0;
          count  <= '0;
          state  <= CALC;
        end
        CALC: begin
          // All W steps always run, even for zero operands, to keep the period fixed.
          if (mplier[0]) begin
            acc <= acc + mcand;
          end
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          count  <= count + CW'(1);
          if (count == LAST_STEP) begin
            state <= DONE;
          end
        end
        DONE: begin
          result <= acc;
          state  <= LOAD;
        end
        default: begin
          state <= LOAD;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multiplier_opt_seq.sv
// Bench for multiplier_opt_seq: a period-level model of when products appear, checked
// every cycle, plus directed vectors with hand-computed products.
module tb_multiplier_opt_seq;

  localparam int W = 3;
  localparam int P = W + 2;

  logic           clk;
  logic           rstn;
  logic [W-1:0]   num1;
  logic [W-1:0]   num2;
  logic [2*W-1:0] result;

  int checks = 0;
  int errors = 0;

  int edge_cnt = 0;
  int latched  = 0;
  int exp_res  = 0;

  multiplier_opt_seq #(.W(W)) dut (
    .clk    (clk),
    .rstn   (rstn),
    .num1   (num1),
    .num2   (num2),
    .result (result)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Model: counting rising edges since reset release, edges 1, 1+P, ... sample the
  // operands and edges P, 2P, ... publish the product sampled at the start of that period.
  always @(posedge clk or posedge rstn) begin
    if (rstn) begin
      edge_cnt = 0;
      latched  = 0;
      exp_res  = 0;
    end else begin
      edge_cnt = edge_cnt + 1;
      if ((edge_cnt - 1) % P == 0) latched = int'(num1) * int'(num2);
      if (edge_cnt % P == 0) exp_res = latched;
    end
  end

  always @(negedge clk) begin
    checks = checks + 1;
    if (int'(result) != exp_res) begin
      errors = errors + 1;
      $display("[TB] FAIL model_cycle t=%0t: result=%0d expected=%0d", $time, result, exp_res);
    end
  end

  task automatic checkOutput(input string name, input int expected);
    checks = checks + 1;
    if (int'(result) != expected) begin
      errors = errors + 1;
      $display("[TB] FAIL %s: result=%0d expected=%0d", name, result, expected);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic applyStimulus(input int a, input int b);
    num1 = W'(a);
    num2 = W'(b);
  endtask

  typedef struct { int a; int b; int p; } vec_t;
  vec_t vecs[5] = '{'{6, 6, 36}, '{5, 3, 15}, '{0, 7, 0}, '{1, 5, 5}, '{7, 1, 7}};

  initial begin
    rstn = 1'b1;
    applyStimulus(7, 7);
    cycles(4);
    checkOutput("reset_hold", 0);

    // Release at a negedge so the next rising edge is the first LOAD.
    rstn = 1'b0;
    cycles(4);
    checkOutput("before_first_done", 0);
    cycles(1);
    checkOutput("max_first", 49);
    cycles(P);
    checkOutput("max_stable", 49);

    // Next edge is a LOAD of 7x7; change the operands right after it.
    cycles(1);
    applyStimulus(2, 3);
    cycles(4);
    checkOutput("change_in_calc_done", 49);
    cycles(4);
    checkOutput("change_in_calc_hold", 49);
    cycles(1);
    checkOutput("change_next_period", 6);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].a, vecs[i].b);
      cycles(2 * P);
      checkOutput($sformatf("directed_%0dx%0d", vecs[i].a, vecs[i].b), vecs[i].p);
    end

    for (int a = 0; a < (1 << W); a++) begin
      for (int b = 0; b < (1 << W); b++) begin
        applyStimulus(a, b);
        cycles(2 * P);
        checkOutput($sformatf("exhaustive_%0dx%0d", a, b), a * b);
      end
    end

    applyStimulus(5, 6);
    cycles(2 * P);
    checkOutput("pre_reset", 30);
    // Land two edges into a period so the reset hits during CALC.
    for (int k = 0; k < P; k++) begin
      if (edge_cnt % P == 2) break;
      @(negedge clk);
    end
    #2 rstn = 1'b1;
    #1 checkOutput("async_reset_mid_calc", 0);
    cycles(2);
    checkOutput("reset_held", 0);
    rstn = 1'b0;
    cycles(P - 1);
    checkOutput("after_release_pending", 0);
    cycles(1);
    checkOutput("after_release_product", 30);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    errors = errors + 1;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
